// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes
// and the select/control codes driven into the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LINK,
        S_LUI
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_R,
        CLS_I
    } alu_class_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_A     = 2'd2;

    localparam logic [1:0] SRCB_WD   = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU function decode for R-type and I-ALU instructions; flags func3 values
// the core does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_class_t  cls,
    input  logic [2:0]  func3,
    input  logic        func7_5,
    output logic [2:0]  alu_control,
    output logic        bad_func
);

    always_comb begin
        alu_control = ALU_ADD;
        bad_func    = 1'b0;
        if (cls != CLS_NONE) begin
            case (func3)
                // func7[5] selects SUB only for register operands; addi has no func7
                3'b000:  alu_control = (cls == CLS_R && func7_5) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_control = ALU_AND;
                3'b110:  alu_control = ALU_OR;
                3'b100:  alu_control = ALU_XOR;
                3'b010:  alu_control = ALU_SLT;
                default: bad_func    = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared-memory multi-cycle RV32I datapath; only
// PCWrite in BRANCH looks at the live zero/lt flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC+4, latch IR/OldPC
// DECODE   | ALUOut <= OldPC+imm (branch/jump target), dispatch
// MEMADR   | ALUOut <= A+imm (load/store address)
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= memory data register
// MEMWRITE | write data memory at ALUOut
// EXECR    | ALUOut <= A op B
// EXECI    | ALUOut <= A op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare A,B; PC <= target when condition holds
// JAL      | PC <= target, ALUOut <= OldPC+4
// JALR     | PC <= A+imm
// LINK     | rd <= OldPC+4
// LUI      | rd <= imm
module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  op,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic        zero,
    input  logic        lt,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic        illegal
);

    state_t     state_q;
    state_t     state_d;
    alu_class_t alu_cls;
    logic [2:0] alu_fn;
    logic       bad_func;
    logic       br_taken;
    logic       func7_unused;

    assign func7_unused = ^{func7[6], func7[4:0]};

    assign alu_cls = (state_q == S_EXECR) ? CLS_R :
                     (state_q == S_EXECI) ? CLS_I : CLS_NONE;

    alu_decoder u_alu_decoder (
        .cls         (alu_cls),
        .func3       (func3),
        .func7_5     (func7[5]),
        .alu_control (alu_fn),
        .bad_func    (bad_func)
    );

    always_comb begin
        case (func3)
            F3_BEQ:  br_taken = zero;
            F3_BNE:  br_taken = !zero;
            F3_BLT:  br_taken = lt;
            F3_BGE:  br_taken = !lt;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = S_MEMADR;
                else if (op == OP_R)            state_d = S_EXECR;
                else if (op == OP_I)            state_d = S_EXECI;
                else if (op == OP_BR)           state_d = S_BRANCH;
                else if (op == OP_JAL)          state_d = S_JAL;
                else if (op == OP_JALR)         state_d = S_JALR;
                else if (op == OP_LUI)          state_d = S_LUI;
                else                            state_d = S_FETCH;
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            S_JAL, S_JALR: state_d = S_LINK;
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_ADD;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_WD;
        ImmSrc     = IMM_I;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (op == OP_BR)       ImmSrc = IMM_B;
                else if (op == OP_JAL) ImmSrc = IMM_J;
                illegal = !op_supported(op);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcA    = SRCA_A;
                ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_WD;
                ALUControl = alu_fn;
                illegal    = bad_func;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = SRCA_A;
                ALUControl = ALU_SUB;
                PCWrite    = br_taken;
            end
            S_JAL: begin
                // target already sits in ALUOut; the ALU is free to form the link value
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_A;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = 1'b1;
            end
            S_LINK: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                RegWrite  = 1'b1;
            end
            S_LUI: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                ALUControl = ALU_PASSB;
                ResultSrc  = RES_ALURESULT;
                RegWrite   = 1'b1;
            end
            default: ;
        endcase
        // reset silences every enable, even mid-instruction
        if (!rst) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            ResultSrc  = '0;
            ALUControl = '0;
            ALUSrcA    = '0;
            ALUSrcB    = '0;
            ImmSrc     = '0;
            illegal    = 1'b0;
        end
    end

endmodule
